// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-clock enable, scan counters, registered sync/video
// decode and a per-signal delay line that re-aligns sync with the RGB pipeline.
module vga_sync_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int TICK_DIV   = 4,
  parameter int SYNC_DELAY = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       video_on_d
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]  HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]  VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]  VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [3:0]  DIV_LAST = 4'(TICK_DIV - 1);

  logic [3:0] div_cnt;
  logic       advance;
  logic       line_end;
  logic       frame_end;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       hsync_next;
  logic       vsync_next;
  logic       video_on_next;

  // Sync and video flags are decoded from the next counter values so the
  // registered outputs change on the same edge as pix_x/pix_y.
  always_comb begin
    advance   = (div_cnt == DIV_LAST);
    line_end  = (pix_x == H_LAST);
    frame_end = line_end && (pix_y == V_LAST);
    x_next    = pix_x;
    y_next    = pix_y;
    if (advance) begin
      if (line_end) begin
        x_next = '0;
        y_next = (pix_y == V_LAST) ? 10'd0 : pix_y + 10'd1;
      end else begin
        x_next = pix_x + 10'd1;
      end
    end
    hsync_next    = !((x_next >= HS_START) && (x_next <= HS_END));
    vsync_next    = !((y_next >= VS_START) && (y_next <= VS_END));
    video_on_next = ({1'b0, x_next} < H_VIS) && ({1'b0, y_next} < V_VIS);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt     <= '0;
      p_tick      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= advance ? 4'd0 : div_cnt + 4'd1;
      p_tick      <= advance;
      pix_x       <= x_next;
      pix_y       <= y_next;
      video_on    <= video_on_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      frame_start <= advance && frame_end;
    end
  end

  // The delay line runs on every CLK, not on p_tick, because it matches a
  // CLK-rate RGB pipeline.
  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hsync_d    = hsync;
      assign vsync_d    = vsync;
      assign video_on_d = video_on;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_sh;
      logic [SYNC_DELAY-1:0] vs_sh;
      logic [SYNC_DELAY-1:0] vo_sh;

      always_ff @(posedge CLK) begin
        if (RESET) begin
          hs_sh <= '1;
          vs_sh <= '1;
          vo_sh <= '0;
        end else begin
          hs_sh[0] <= hsync;
          vs_sh[0] <= vsync;
          vo_sh[0] <= video_on;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_sh[i] <= hs_sh[i-1];
            vs_sh[i] <= vs_sh[i-1];
            vo_sh[i] <= vo_sh[i-1];
          end
        end
      end

      assign hsync_d    = hs_sh[SYNC_DELAY-1];
      assign vsync_d    = vs_sh[SYNC_DELAY-1];
      assign video_on_d = vo_sh[SYNC_DELAY-1];
    end
  endgenerate

endmodule
